// File: rtl/timer_counter.sv
// Clock-divided 8-bit up/down timer core: a 4-bit prescaler produces the count
// tick and the counter raises one-cycle overflow/underflow pulses on wrap.
module timer_counter (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       EN_IN,
    input  logic       LOAD_IN,
    input  logic [7:0] TDR_IN,
    input  logic       UP_DOWN_IN,
    input  logic [1:0] CLK_SEL_IN,
    output logic [7:0] TCNT_OUT,
    output logic       OVF_OUT,
    output logic       UNDF_OUT
);

    logic [3:0] psc_r;
    logic [3:0] psc_nxt_s;
    logic [7:0] tcnt_r;
    logic [7:0] tcnt_nxt_s;
    logic       ovf_r;
    logic       ovf_nxt_s;
    logic       undf_r;
    logic       undf_nxt_s;
    logic       psc_match_s;
    logic       tick_s;

    // Prescaler compare: low CLK_SEL_IN+1 bits of the prescaler all ones.
    always_comb begin
        psc_match_s = 1'b0;
        case (CLK_SEL_IN)
            2'b00:   psc_match_s = psc_r[0];
            2'b01:   psc_match_s = &psc_r[1:0];
            2'b10:   psc_match_s = &psc_r[2:0];
            2'b11:   psc_match_s = &psc_r[3:0];
            default: psc_match_s = 1'b0;
        endcase
    end

    assign tick_s = EN_IN & ~LOAD_IN & psc_match_s;

    // Next-state for prescaler, counter and wrap pulses; load beats any tick.
    always_comb begin
        psc_nxt_s  = 4'd0;
        tcnt_nxt_s = tcnt_r;
        ovf_nxt_s  = 1'b0;
        undf_nxt_s = 1'b0;
        if (LOAD_IN || !EN_IN) begin
            psc_nxt_s = 4'd0;
        end else begin
            psc_nxt_s = psc_r + 4'd1;
        end
        if (LOAD_IN) begin
            tcnt_nxt_s = TDR_IN;
        end else if (tick_s && !UP_DOWN_IN) begin
            tcnt_nxt_s = tcnt_r + 8'd1;
            ovf_nxt_s  = (tcnt_r == 8'hFF);
        end else if (tick_s) begin
            tcnt_nxt_s = tcnt_r - 8'd1;
            undf_nxt_s = (tcnt_r == 8'h00);
        end else begin
            tcnt_nxt_s = tcnt_r;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            psc_r  <= 4'd0;
            tcnt_r <= 8'h00;
            ovf_r  <= 1'b0;
            undf_r <= 1'b0;
        end else begin
            psc_r  <= psc_nxt_s;
            tcnt_r <= tcnt_nxt_s;
            ovf_r  <= ovf_nxt_s;
            undf_r <= undf_nxt_s;
        end
    end

    assign TCNT_OUT = tcnt_r;
    assign OVF_OUT  = ovf_r;
    assign UNDF_OUT = undf_r;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter; outputs are sampled 1 ns
// after each rising edge and compared against hand-computed values.
`timescale 1ns/1ps
module tb_timer_counter;

    logic       PCLK;
    logic       PRESETn;
    logic       EN_IN;
    logic       LOAD_IN;
    logic [7:0] TDR_IN;
    logic       UP_DOWN_IN;
    logic [1:0] CLK_SEL_IN;
    logic [7:0] TCNT_OUT;
    logic       OVF_OUT;
    logic       UNDF_OUT;

    int checks = 0;
    int errors = 0;

    timer_counter dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .EN_IN      (EN_IN),
        .LOAD_IN    (LOAD_IN),
        .TDR_IN     (TDR_IN),
        .UP_DOWN_IN (UP_DOWN_IN),
        .CLK_SEL_IN (CLK_SEL_IN),
        .TCNT_OUT   (TCNT_OUT),
        .OVF_OUT    (OVF_OUT),
        .UNDF_OUT   (UNDF_OUT)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] cnt,
                             input logic ovf, input logic undf);
        chk({tag, "_tcnt"}, TCNT_OUT, cnt);
        chk({tag, "_ovf"},  {7'd0, OVF_OUT},  {7'd0, ovf});
        chk({tag, "_undf"}, {7'd0, UNDF_OUT}, {7'd0, undf});
    endtask

    initial begin
        PRESETn    = 1'b0;
        EN_IN      = 1'b0;
        LOAD_IN    = 1'b0;
        TDR_IN     = 8'h00;
        UP_DOWN_IN = 1'b0;
        CLK_SEL_IN = 2'b00;
        step(2);
        chk_state("reset", 8'h00, 1'b0, 1'b0);

        // Up-count at /2 from reset release
        EN_IN   = 1'b1;
        PRESETn = 1'b1;
        step(1);
        chk_state("up2_e1", 8'h00, 1'b0, 1'b0);
        step(1);
        chk_state("up2_e2", 8'h01, 1'b0, 1'b0);
        step(8);
        chk_state("up2_e10", 8'h05, 1'b0, 1'b0);

        // Load FE, /4 up, overflow at load+8
        LOAD_IN    = 1'b1;
        TDR_IN     = 8'hFE;
        CLK_SEL_IN = 2'b01;
        step(1);
        chk_state("ldfe", 8'hFE, 1'b0, 1'b0);
        LOAD_IN = 1'b0;
        step(3);
        chk_state("ldfe_p3", 8'hFE, 1'b0, 1'b0);
        step(1);
        chk_state("ldfe_p4", 8'hFF, 1'b0, 1'b0);
        step(3);
        chk_state("ldfe_p7", 8'hFF, 1'b0, 1'b0);
        step(1);
        chk_state("ldfe_p8", 8'h00, 1'b1, 1'b0);
        step(1);
        chk_state("ldfe_p9", 8'h00, 1'b0, 1'b0);

        // Load 01, /2 down, underflow at load+4
        LOAD_IN    = 1'b1;
        TDR_IN     = 8'h01;
        UP_DOWN_IN = 1'b1;
        CLK_SEL_IN = 2'b00;
        step(1);
        chk_state("ld01", 8'h01, 1'b0, 1'b0);
        LOAD_IN = 1'b0;
        step(2);
        chk_state("ld01_p2", 8'h00, 1'b0, 1'b0);
        step(2);
        chk_state("ld01_p4", 8'hFF, 1'b0, 1'b1);
        step(1);
        chk_state("ld01_p5", 8'hFF, 1'b0, 1'b0);

        // /16 up from 00 for 48 edges, then hold with EN_IN low
        LOAD_IN    = 1'b1;
        TDR_IN     = 8'h00;
        UP_DOWN_IN = 1'b0;
        CLK_SEL_IN = 2'b11;
        step(1);
        LOAD_IN = 1'b0;
        step(47);
        chk_state("d16_e47", 8'h02, 1'b0, 1'b0);
        step(1);
        chk_state("d16_e48", 8'h03, 1'b0, 1'b0);
        EN_IN = 1'b0;
        step(20);
        chk_state("d16_hold", 8'h03, 1'b0, 1'b0);
        EN_IN = 1'b1;
        step(15);
        chk_state("d16_re15", 8'h03, 1'b0, 1'b0);
        step(1);
        chk_state("d16_re16", 8'h04, 1'b0, 1'b0);

        // Load collides with a FF->00 tick
        LOAD_IN    = 1'b1;
        TDR_IN     = 8'hFF;
        CLK_SEL_IN = 2'b00;
        step(1);
        chk_state("ldff", 8'hFF, 1'b0, 1'b0);
        LOAD_IN = 1'b0;
        step(1);
        chk_state("ldff_p1", 8'hFF, 1'b0, 1'b0);
        LOAD_IN = 1'b1;
        TDR_IN  = 8'h80;
        step(1);
        chk_state("ld80_coll", 8'h80, 1'b0, 1'b0);
        LOAD_IN = 1'b0;
        step(1);
        chk_state("ld80_p1", 8'h80, 1'b0, 1'b0);

        // Asynchronous reset mid-count at 37
        LOAD_IN    = 1'b1;
        TDR_IN     = 8'h37;
        CLK_SEL_IN = 2'b01;
        step(1);
        LOAD_IN = 1'b0;
        step(2);
        chk_state("pre_rst", 8'h37, 1'b0, 1'b0);
        #2;
        PRESETn = 1'b0;
        #1;
        chk_state("async_rst", 8'h00, 1'b0, 1'b0);
        #1;
        PRESETn = 1'b1;
        step(3);
        chk_state("rel_e3", 8'h00, 1'b0, 1'b0);
        step(1);
        chk_state("rel_e4", 8'h01, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Clock-divided 8-bit up/down counting core of the 8-bit timer. It divides PCLK by the ratio selected by the control logic's clock-select output and counts up or down on each divided tick. It can be preloaded from the data register, and it raises single-cycle overflow/underflow pulses. Those pulses feed the control logic's OVF_IN/UNDF_IN inputs, which in turn update TSR status.

## Interface
Parameters:
- none; all widths fixed (8-bit counter, 2-bit clock select, 4-bit prescaler)

Ports:
- PCLK  in  1  system clock; single clock domain; all state updates on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- EN_IN  in  1  count enable (timer start); 0 = counter holds, prescaler cleared
- LOAD_IN  in  1  load strobe; TCNT_OUT <= TDR_IN on the next edge
- TDR_IN  in  8  preload value from the data register
- UP_DOWN_IN  in  1  direction; 0 = count up, 1 = count down
- CLK_SEL_IN  in  2  divide select from control logic CLK_SEL_OUT; 00=/2, 01=/4, 10=/8, 11=/16
- TCNT_OUT  out  8  current count, registered
- OVF_OUT  out  1  one-PCLK pulse when an up-count wraps FF->00
- UNDF_OUT  out  1  one-PCLK pulse when a down-count wraps 00->FF

## Operation
- Prescaler: 4-bit register PSC.
  - Increments every PCLK while EN_IN=1 and LOAD_IN=0.
  - Forced to 0 when EN_IN=0 or LOAD_IN=1.
  - Wraps 15->0.
- Tick: combinational.
  - tick = EN_IN & ~LOAD_IN & (PSC[N:0] all ones), where N = CLK_SEL_IN.
  - Result: one tick every 2^(CLK_SEL_IN+1) PCLKs.
- CLK_SEL_IN change mid-count: PSC is not cleared; the new ratio applies from the next PSC compare. The first period after the change may be short.
- Priority per edge, highest first:
  1. LOAD_IN=1: TCNT <= TDR_IN; OVF_OUT/UNDF_OUT <= 0. Load is accepted regardless of EN_IN.
  2. tick with UP_DOWN_IN=0: TCNT <= TCNT+1 mod 256; OVF_OUT <= (TCNT==8'hFF).
  3. tick with UP_DOWN_IN=1: TCNT <= TCNT-1 mod 256; UNDF_OUT <= (TCNT==8'h00).
  4. Otherwise: TCNT holds; OVF_OUT <= 0; UNDF_OUT <= 0.
- OVF_OUT and UNDF_OUT are never asserted together. Each is high for exactly one PCLK per wrap.
- A direction change takes effect at the next tick. No pending state is kept.
- No state machine beyond the prescaler and the counter. Stopped/running is purely EN_IN.

## Timing
- Reset values (async, immediate on PRESETn low): TCNT_OUT=8'h00, OVF_OUT=0, UNDF_OUT=0, PSC=0.
- After reset release with EN_IN=1, the first tick occurs on the 2^(CLK_SEL_IN+1)-th rising edge. Example: sel=00 gives the first increment at edge 2.
- Load latency: 1 PCLK. TCNT_OUT shows TDR_IN after the edge sampling LOAD_IN=1.
- After a load with EN_IN=1 held, the first tick occurs 2^(sel+1) edges after the load edge.
- Wrap timing: OVF_OUT/UNDF_OUT rise on the same edge that TCNT_OUT becomes 00/FF, and fall on the next edge.
- Reset asserted mid-count clears everything within the same cycle. Counting restarts from 00 with PSC=0 after release.
- EN_IN deasserted on a tick cycle: the tick is suppressed (tick includes EN_IN); TCNT holds.

## Test plan
- Reset, then EN_IN=1, UP_DOWN_IN=0, CLK_SEL_IN=00 for 10 edges -> TCNT_OUT steps 00->01 at edge 2, reaches 05 at edge 10; OVF_OUT and UNDF_OUT stay 0.
- Load TDR_IN=8'hFE, sel=01, up, run 8 edges -> TCNT_OUT=FE, then FF at load+4, then 00 at load+8 with OVF_OUT=1 for exactly one cycle.
- Load 8'h01, UP_DOWN_IN=1, sel=00 -> 00 at load+2, then FF at load+4 with UNDF_OUT=1 for one cycle, OVF_OUT=0.
- sel=11, count up from 00 for 48 edges -> TCNT_OUT=03. Then EN_IN=0 for 20 edges -> TCNT_OUT holds 03. Then EN_IN=1 -> next increment 16 edges later.
- LOAD_IN asserted on the same edge as a FF->00 tick (TDR_IN=8'h80) -> TCNT_OUT=80, OVF_OUT stays 0.
- PRESETn pulsed low mid-count (TCNT=8'h37) -> TCNT_OUT=00 immediately without waiting for an edge; pulses 0; after release, the first tick occurs at 2^(sel+1) edges.
